// File: rtl/div_seq.sv
// div_seq: sequential unsigned restoring divider.
// One shift-subtract iteration per clock through a single WIDTH+2 bit
// subtractor, with a start/done handshake and a divide-by-zero fast path.
module div_seq #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // Counter must be able to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
  } step_t;

  // One restoring iteration: shift the next dividend bit into the partial
  // remainder and subtract the divisor. The top bit of the WIDTH+2 bit
  // difference is the borrow; on borrow the shifted remainder is kept.
  function automatic step_t div_step(
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] r,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH:0]   t;
    logic [WIDTH+1:0] diff;
    step_t            res;
    t    = {r, q[WIDTH-1]};
    diff = {1'b0, t} - {2'b00, d};
    if (diff[WIDTH+1]) begin
      res.r = t[WIDTH-1:0];
      res.q = {q[WIDTH-2:0], 1'b0};
    end else begin
      res.r = diff[WIDTH-1:0];
      res.q = {q[WIDTH-2:0], 1'b1};
    end
    return res;
  endfunction

  state_t           state_r, state_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic [WIDTH-1:0] r_r, r_n;
  logic [WIDTH-1:0] d_r, d_n;
  logic [CW-1:0]    cnt_r, cnt_n;
  logic             dbz_r, dbz_n;
  step_t            step_s;

  // Next-state and datapath decode; every register holds unless its state says otherwise.
  always_comb begin
    state_n = state_r;
    q_n     = q_r;
    r_n     = r_r;
    d_n     = d_r;
    cnt_n   = cnt_r;
    dbz_n   = dbz_r;
    step_s  = div_step(q_r, r_r, d_r);

    case (state_r)
      IDLE: begin
        if (start) begin
          if (divisor != {WIDTH{1'b0}}) begin
            q_n     = dividend;
            r_n     = {WIDTH{1'b0}};
            d_n     = divisor;
            cnt_n   = CW'(WIDTH);
            dbz_n   = 1'b0;
            state_n = RUN;
          end else begin
            // Fast path: no iterations, results are fixed by convention.
            q_n     = {WIDTH{1'b1}};
            r_n     = dividend;
            d_n     = divisor;
            cnt_n   = {CW{1'b0}};
            dbz_n   = 1'b1;
            state_n = DONE;
          end
        end else begin
          state_n = IDLE;
        end
      end

      RUN: begin
        q_n   = step_s.q;
        r_n   = step_s.r;
        cnt_n = cnt_r - CW'(1);
        // cnt reaching zero on this edge means WIDTH iterations are complete.
        if (cnt_r == CW'(1)) begin
          state_n = DONE;
        end else begin
          state_n = RUN;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any start on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      q_r     <= {WIDTH{1'b0}};
      r_r     <= {WIDTH{1'b0}};
      d_r     <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      dbz_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      q_r     <= q_n;
      r_r     <= r_n;
      d_r     <= d_n;
      cnt_r   <= cnt_n;
      dbz_r   <= dbz_n;
    end
  end

  // Outputs come straight from registers or a decode of the state register.
  assign busy        = (state_r != IDLE);
  assign done        = (state_r == DONE);
  assign quotient    = q_r;
  assign remainder   = r_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and exhaustive self-checking bench for div_seq.
module tb_div_seq;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries: {quotient, remainder, div_by_zero}
  logic [2*W:0] sb_q[$];

  div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Global time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == '0) return {{W{1'b1}}, a, 1'b1};
    q = a / b;
    r = a % b;
    return {q, r, 1'b0};
  endfunction

  task automatic compare_results(input string op);
    logic [2*W:0] exp;
    if (sb_q.size() == 0) begin
      check({"sb_nonempty ", op}, 32'(sb_q.size()), 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check({"quotient ", op},    32'(quotient),    32'(exp[2*W:W+1]));
      check({"remainder ", op},   32'(remainder),   32'(exp[W:1]));
      check({"div_by_zero ", op}, 32'(div_by_zero), 32'(exp[0]));
    end
  endtask

  // Issue one division from IDLE, wait for done, compare against the scoreboard.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit full);
    int    c;
    string op;
    op       = $sformatf("%0d/%0d", a, b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    sb_q.push_back(model(a, b));
    if (full) check({"busy_after_accept ", op}, 32'(busy), 32'd1);
    c = 0;
    while (!done && c < 20) begin
      tick();
      c++;
    end
    check({"done_seen ", op}, 32'(done), 32'd1);
    if (full) check({"done_latency ", op}, 32'(c), (b == '0) ? 32'd0 : 32'(W));
    compare_results(op);
    tick();
    if (full) begin
      check({"done_single_pulse ", op}, 32'(done), 32'd0);
      check({"busy_fall ", op},         32'(busy), 32'd0);
    end
  endtask

  initial begin
    int           pulses;
    int           c;
    logic [W-1:0] hold_q;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("reset_busy",        32'(busy),        32'd0);
    check("reset_done",        32'(done),        32'd0);
    check("reset_quotient",    32'(quotient),    32'd0);
    check("reset_remainder",   32'(remainder),   32'd0);
    check("reset_div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    tick();

    // Basic case and boundaries.
    do_div(5'd23, 5'd4, 1'b1);
    hold_q = quotient;
    tick();
    tick();
    check("quotient_holds", 32'(quotient), 32'(hold_q));
    do_div(5'd31, 5'd1, 1'b1);
    do_div(5'd7,  5'd9, 1'b1);
    do_div(5'd0,  5'd5, 1'b1);
    do_div(5'd31, 5'd31, 1'b1);

    // Divide by zero, then an ordinary division clears the flag.
    do_div(5'd20, 5'd0, 1'b1);
    do_div(5'd10, 5'd3, 1'b1);

    // start held high, operands changing during RUN/DONE.
    dividend = 5'd25;
    divisor  = 5'd6;
    start    = 1'b1;
    tick();
    sb_q.push_back(model(5'd25, 5'd6));
    dividend = 5'd9;
    divisor  = 5'd2;
    pulses   = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) begin
        pulses++;
        compare_results("25/6 held");
      end
    end
    check("held_start_pulses",   32'(pulses), 32'd1);
    check("held_start_idle_k6",  32'(busy),   32'd0);
    tick();
    check("held_start_accept_k7", 32'(busy), 32'd1);
    sb_q.push_back(model(5'd9, 5'd2));
    start = 1'b0;
    c = 0;
    while (!done && c < 20) begin
      tick();
      c++;
    end
    check("done_seen 9/2", 32'(done), 32'd1);
    compare_results("9/2 retry");
    tick();

    // Reset during RUN discards the operation.
    dividend = 5'd29;
    divisor  = 5'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy",        32'(busy),        32'd0);
    check("midrst_done",        32'(done),        32'd0);
    check("midrst_quotient",    32'(quotient),    32'd0);
    check("midrst_remainder",   32'(remainder),   32'd0);
    check("midrst_div_by_zero", 32'(div_by_zero), 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    do_div(5'd29, 5'd3, 1'b1);

    // Exhaustive sweep of all operand pairs.
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        do_div(W'(a), W'(b), 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
